// File: rtl/hex_str_serializer.sv
// -----------------------------------------------------------------------------
// hex_str_serializer
//   Captures one parallel ASCII hex string from the binary-to-hex stage. It then
//   streams the string one byte per accepted handshake, leftmost character
//   first. When APPEND_CRLF is set, it follows the digits with 8'h0D and 8'h0A.
//   A captured string is held until its final byte has been accepted. A new
//   string is refused (in_ready=0) for the whole transaction.
//
// Parameters
//   N           : binary width of the upstream converter. Must be a multiple
//                 of 4 and >= 4. The string has N/4 characters.
//   APPEND_CRLF : 1 appends CR then LF after the digits. 0 sends digits only.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous, active-high reset
//   in_valid   in   hex_str is valid
//   in_ready   out  block can capture a string (IDLE only)
//   hex_str    in   (N/4)*8 ASCII characters, leftmost in the top byte
//   out_valid  out  out_byte is valid
//   out_ready  in   consumer accepts out_byte
//   out_byte   out  current character (8'h00 when idle)
//   out_last   out  final byte of the transaction
//   busy       out  high from capture until the final byte is accepted
// -----------------------------------------------------------------------------
module hex_str_serializer #(
  parameter int N           = 32,
  parameter bit APPEND_CRLF = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [(N/4)*8-1:0] hex_str,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [7:0]         out_byte,
  output logic               out_last,
  output logic               busy
);

  localparam int CHARS = N / 4;
  localparam int W     = CHARS * 8;
  localparam int CW    = (CHARS > 1) ? $clog2(CHARS) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(CHARS - 1);

  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIGITS = 2'd1,
    TERM   = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [W-1:0]   shreg;
  logic [CW-1:0]  cnt;
  logic           term_idx;   // 0: presenting CR, 1: presenting LF
  logic           capture;
  logic           accept;
  logic           last_digit;

  assign last_digit = (cnt == LAST_CNT);
  assign capture    = in_valid && in_ready;
  assign accept     = out_valid && out_ready;
  assign busy       = (state != IDLE);

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking (=) here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every output of this block gets a default before the case statement,
  // so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_byte  = 8'h00;
    out_last  = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nxt = DIGITS;
        end
      end
      DIGITS: begin
        out_valid = 1'b1;
        out_byte  = shreg[W-1 -: 8];
        out_last  = !APPEND_CRLF && last_digit;
        if (out_ready && last_digit) begin
          state_nxt = APPEND_CRLF ? TERM : IDLE;
        end
      end
      TERM: begin
        out_valid = 1'b1;
        out_byte  = term_idx ? LF : CR;
        out_last  = term_idx;
        if (out_ready && term_idx) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath. The string register is reset along with the control state, so
  // an aborted transaction leaves no stale characters behind.
  // NOTE: this wide shift register is deliberately reset. Idle out_byte is
  // forced to zero anyway, but a defined post-reset image keeps equivalence
  // and X-propagation checks simple.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg    <= '0;
      cnt      <= '0;
      term_idx <= 1'b0;
    end else if (capture) begin
      shreg    <= hex_str;
      cnt      <= '0;
      term_idx <= 1'b0;
    end else if (accept && (state == DIGITS)) begin
      shreg <= shreg << 8;
      // Hold at the final index; the state change ends the digit phase.
      if (!last_digit) begin
        cnt <= cnt + 1'b1;
      end
    end else if (accept && (state == TERM)) begin
      term_idx <= ~term_idx;
    end
  end

endmodule

// File: doc/hex_str_serializer.md
# hex_str_serializer

Converts the parallel ASCII hex string produced by the binary-to-hex stage into a byte stream, most significant character first. An optional CR/LF pair terminates the stream. It sits directly downstream of the binary-to-hex converter and feeds a byte-wide consumer such as a UART transmitter through a valid/ready handshake. It captures one whole string per transaction and holds it until the last byte has been accepted.

## Interface
- N, default 32: binary width of the upstream converter. Must be a multiple of 4 and ≥ 4. The string has N/4 characters.
- APPEND_CRLF, default 1: 1 appends 8'h0D then 8'h0A after the digits; 0 sends digits only.
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  hex_str is valid.
- in_ready  output  1  block can capture a string.
- hex_str  input  (N/4)*8  ASCII characters. Leftmost character is in bits [(N/4)*8-1 -: 8].
- out_valid  output  1  out_byte is valid.
- out_ready  input  1  consumer accepts out_byte.
- out_byte  output  8  current character.
- out_last  output  1  high with the final byte of the transaction.
- busy  output  1  high from capture until the final byte is accepted.

## Operation
- State machine has three states: IDLE, DIGITS and TERM.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready: register hex_str into a shift register, clear the character counter, go to DIGITS.
- DIGITS:
  - out_valid=1; out_byte is the top 8 bits of the shift register.
  - On out_valid&&out_ready: shift left 8, increment the counter.
  - When the counter reaches N/4-1 and that byte is accepted:
    - go to TERM if APPEND_CRLF=1;
    - go to IDLE otherwise.
- TERM (APPEND_CRLF=1 only):
  - out_valid=1; out_byte=8'h0D, then 8'h0A, selected by a 1-bit index.
  - Acceptance of 8'h0A returns to IDLE.
- out_last:
  - APPEND_CRLF=1: high only while presenting 8'h0A.
  - APPEND_CRLF=0: high only while presenting the N/4-th digit.
- busy = (state != IDLE).
- Character contents are passed through unchecked; any byte value, including "X", is sent verbatim.
- in_valid while not in IDLE is ignored. in_ready=0, and the pending string is neither captured nor queued.
- Counter width is clog2(N/4), minimum 1 bit. The counter never wraps inside a transaction.

## Timing
- Reset values:
  - state=IDLE, in_ready=1, out_valid=0, out_byte=8'h00, out_last=0, busy=0;
  - shift register and counters are 0.
- Reset asserted mid-transaction aborts immediately (asynchronously). The remaining bytes are discarded. After deassertion the block is in IDLE.
- Latency: a capture at edge k puts the first character on out_byte with out_valid=1 after edge k.
- Throughput is one byte per cycle while out_ready=1.
- One transaction takes N/4 + 2·APPEND_CRLF byte cycles.
- in_ready rises in the cycle after the final byte is accepted. There is no same-cycle re-capture, so there is at least one idle cycle between transactions.
- While out_valid=1 and out_ready=0, out_byte and out_last hold stable and out_valid stays high. out_valid never drops without acceptance.
- out_ready while out_valid=0 has no effect.

## Test plan
- N=32, APPEND_CRLF=1:
  - Stimulus: hex_str="DEADBEEF", in_valid pulsed for 1 cycle, out_ready held at 1.
  - Required response: bytes 44 45 41 44 42 45 45 46 0D 0A on 10 consecutive cycles starting the cycle after capture. out_last only on 0A. busy falls after 0A is accepted.
- Backpressure:
  - Stimulus: same string, out_ready toggled 1,0,0,1,…
  - Required response: each byte is held stable across stall cycles. The sequence is unchanged and no byte is duplicated or dropped.
- Busy rejection:
  - Stimulus: "01234567" captured, then in_valid held high with "FFFFFFFF" throughout the transaction.
  - Required response: in_ready=0 while busy and only "01234567"+CRLF is output. "FFFFFFFF" is captured one idle cycle after 0A is accepted.
- Reset mid-stream:
  - Stimulus: rst asserted after the third byte of "CAFEF00D".
  - Required response: out_valid=0, out_byte=00 and busy=0 immediately. After release, a new "00000001" streams correctly from its first character.
- N=8, APPEND_CRLF=0:
  - Stimulus: hex_str="7F".
  - Required response: bytes 37 then 46, out_last on 46, then return to IDLE.
- Reset state:
  - Stimulus: assert rst with no other activity.
  - Required response: all outputs at their reset values and in_ready=1 during and after reset.
